// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and byte-level helpers for the round sequencer.
// Bytes are numbered 0..15 from the MSB; byte 4c+r sits in column c, row r.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_state_e;

    localparam int BYTE_W = 8;
    localparam int COL_W  = 32;
    localparam int BLK_W  = 128;
    localparam int COLS   = 4;
    localparam int BYTES  = 16;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10)
            rc = RCON[idx];
        return rc;
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < BYTES; i++)
            o[BLK_W-1-BYTE_W*i -: BYTE_W] = SBOX[s[BLK_W-1-BYTE_W*i -: BYTE_W]];
        return o;
    endfunction

    // Row r of the output takes column (c+r) mod 4 of the input.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < 4; r++)
                o[BLK_W-1-BYTE_W*(4*c+r) -: BYTE_W] = s[BLK_W-1-BYTE_W*(4*((c+r)%4)+r) -: BYTE_W];
        return o;
    endfunction

endpackage

// File: rtl/Mix_Column.sv
// MixColumns on a single 32-bit column; row 0 occupies the most significant byte.
module Mix_Column (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // 3*x is computed as xtime(x) ^ x.
    assign col_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_key_step.sv
// Combinational AES-128 key schedule step: next round key from the current one and its RCON.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] rkey,
    input  logic [7:0]       rcon,
    output logic [BLK_W-1:0] next_key
);

    logic [COL_W-1:0] w    [COLS];
    logic [COL_W-1:0] nw   [COLS];
    logic [COL_W-1:0] temp;

    // SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}
    assign temp = {SBOX[w[3][23:16]], SBOX[w[3][15:8]], SBOX[w[3][7:0]], SBOX[w[3][31:24]]}
                  ^ {rcon, 24'h000000};

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_word
            assign w[gi] = rkey[BLK_W-1-COL_W*gi -: COL_W];
            if (gi == 0) begin : g_head
                assign nw[gi] = w[gi] ^ temp;
            end else begin : g_chain
                assign nw[gi] = w[gi] ^ nw[gi-1];
            end
            assign next_key[BLK_W-1-COL_W*gi -: COL_W] = nw[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock around a single state register,
// with the round key expanded on the fly alongside it.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic [BLK_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy,
    output logic [3:0]       round_idx
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    fsm_state_e       state_reg, state_next;
    logic [BLK_W-1:0] data_reg, data_next;
    logic [BLK_W-1:0] key_reg, key_next;
    logic [3:0]       round_reg, round_next;

    logic [7:0]       rcon;
    logic [BLK_W-1:0] round_key;
    logic [BLK_W-1:0] sr_state;
    logic [BLK_W-1:0] mc_state;

    assign rcon     = rcon_of(round_reg);
    assign sr_state = shift_rows(sub_bytes(data_reg));

    aes_key_step u_key_step (
        .rkey     (key_reg),
        .rcon     (rcon),
        .next_key (round_key)
    );

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_mix
            Mix_Column u_mix (
                .col_in  (sr_state[BLK_W-1-COL_W*gi -: COL_W]),
                .col_out (mc_state[BLK_W-1-COL_W*gi -: COL_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            key_reg   <= '0;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            key_reg   <= key_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        key_next   = key_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data ^ in_key;
                    key_next   = in_key;
                    round_next = 4'd1;
                    state_next = (NUM_ROUNDS == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                data_next  = mc_state ^ round_key;
                key_next   = round_key;
                round_next = (round_reg < LAST) ? round_reg + 4'd1 : LAST;
                if (round_reg >= LAST - 4'd1)
                    state_next = FINAL;
            end
            FINAL: begin
                // Last round has no MixColumns.
                data_next  = sr_state ^ round_key;
                key_next   = round_key;
                round_next = 4'd0;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it stays low for the whole reset pulse.
    assign in_ready  = rst_n && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = data_reg;
    assign round_idx = round_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a byte-array AES reference plus a
// transaction-level timing model, checked against the DUT on every falling edge.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         or_dir = 1'b0;
    logic         or_rnd = 1'b0;
    logic         rand_mode = 1'b0;
    logic         out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic [3:0]   round_idx;

    assign out_ready = rand_mode ? or_rnd : or_dir;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference AES built from GF(2^8) arithmetic ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [7:0]   coef [4];
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        rk = round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
            if (r < NR) begin
                for (int c = 0; c < 4; c++)
                    for (int w = 0; w < 4; w++) begin
                        s[4*c+w] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[4*c+w] = s[4*c+w] ^ gmul(coef[(k - w + 4) % 4], t[4*c+k]);
                    end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            rk = round_key(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction timing model ----------------
    // m_cnt = edges since the accept edge; outputs are due NR edges after it.
    bit           m_busy = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_exp = '0;
    int           acc_cnt = 0;
    int           del_cnt = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [127:0] expq [$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            expq.delete();
        end else begin
            cyc++;
            if (out_valid && out_ready) begin
                del_cnt++;
                chk("delivery_has_pending_block", 128'(expq.size() > 0), 128'(1));
                if (expq.size() > 0) chk("delivery_order_data", out_data, expq.pop_front());
            end
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy  = 1'b1;
                    m_cnt   = 1;
                    m_exp   = aes_ref(in_data, in_key);
                    expq.push_back(m_exp);
                    acc_cnt++;
                    acc_cyc = cyc;
                    $display("[TB] accept #%0d pt=%h key=%h exp=%h", acc_cnt, in_data, in_key, m_exp);
                end
            end else if (m_cnt <= NR) begin
                m_cnt++;
            end else if (out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    initial forever @(posedge clk) or_rnd <= ($urandom_range(0, 9) < 7);

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready", 128'(in_ready), 128'(0));
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_round_idx", 128'(round_idx), 128'(0));
            chk("rst_out_data", out_data, 128'(0));
        end else begin
            chk("in_ready", 128'(in_ready), 128'(!m_busy));
            chk("busy", 128'(busy), 128'(m_busy));
            chk("out_valid", 128'(out_valid), 128'(m_busy && m_cnt == NR + 1));
            chk("round_idx", 128'(round_idx), 128'((m_busy && m_cnt <= NR) ? m_cnt : 0));
            if (m_busy && m_cnt == NR + 1) chk("out_data", out_data, m_exp);
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] key, input bit hold);
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        while (acc_cnt == start && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_within_bound", 128'(acc_cnt - start), 128'(1));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_within_bound", 128'(out_valid), 128'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_within_bound", 128'(m_busy), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a1, a2, d0;
        logic [127:0] held;

        build_sbox();
        chk("model_sbox_00", 128'(sbox_m[0]), 128'h63);
        chk("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        chk("model_rk10_appB", round_key(B_KEY, 10), B_RK10);
        chk("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
        chk("model_appB", aes_ref(B_PT, B_KEY), B_CT);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: FIPS-197 C.1 with latency
        or_dir = 1'b1;
        send(C1_PT, C1_KEY, 1'b0);
        wait_out_valid(n);
        chk("c1_latency_edges", 128'(n), 128'(NR));
        chk("c1_ciphertext", out_data, C1_CT);
        wait_idle();

        // 2: FIPS-197 App.B with round_idx sequence and busy span
        send(B_PT, B_KEY, 1'b0);
        for (int k = 1; k <= NR; k++) begin
            chk("appB_round_idx", 128'(round_idx), 128'(k));
            chk("appB_busy", 128'(busy), 128'(1));
            @(posedge clk); #1;
        end
        chk("appB_done_valid", 128'(out_valid), 128'(1));
        chk("appB_done_idx", 128'(round_idx), 128'(0));
        chk("appB_ciphertext", out_data, B_CT);
        @(posedge clk); #1;
        chk("appB_busy_after", 128'(busy), 128'(0));

        // 3: backpressure
        or_dir = 1'b0;
        send(C1_PT, C1_KEY, 1'b0);
        wait_out_valid(n);
        held = out_data;
        d0 = del_cnt;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("bp_data_stable", out_data, held);
            chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        or_dir = 1'b1;
        @(posedge clk); #1;
        chk("bp_one_handshake", 128'(del_cnt - d0), 128'(1));
        chk("bp_valid_dropped", 128'(out_valid), 128'(0));
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));

        // 4: back-to-back with in_valid held
        send(C1_PT, C1_KEY, 1'b1);
        a1 = acc_cyc;
        send(B_PT, B_KEY, 1'b0);
        a2 = acc_cyc;
        chk("b2b_spacing", 128'(a2 - a1), 128'(NR + 2));
        wait_idle();

        // 5: reset in round 5
        send(C1_PT, C1_KEY, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_mid_round5", 128'(round_idx), 128'(5));
        d0 = del_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_round_idx", 128'(round_idx), 128'(0));
        chk("rst_mid_out_data", out_data, 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_no_delivery", 128'(del_cnt - d0), 128'(0));
        chk("rst_mid_ready_after", 128'(in_ready), 128'(1));
        send(C1_PT, C1_KEY, 1'b0);
        wait_out_valid(n);
        chk("rst_mid_c1_after", out_data, C1_CT);
        wait_idle();

        // 6: random blocks with random gaps and sink stalls
        d0 = del_cnt;
        rand_mode = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        n = 0;
        while ((expq.size() > 0 || m_busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        rand_mode = 1'b0;
        chk("rand_queue_drained", 128'(expq.size()), 128'(0));
        chk("rand_delivered_count", 128'(del_cnt - d0), 128'(1000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
